// File: rtl/freq_gate_controller.sv
// rtl/freq_gate_controller.sv - gate sequencer for the frequency counter datapath
module freq_gate_controller #(
    parameter int GATE_CYCLES = 50,
    parameter int DEBOUNCE    = 4,
    parameter int CW          = 8
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iSenal,
    input  logic iStart,
    input  logic iContinuous,
    input  logic iOvf,
    input  logic iReady,
    output logic oCntClr,
    output logic oCntInc,
    output logic oLatch,
    output logic oGate,
    output logic oBusy,
    output logic oValid,
    output logic oOverrange
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        LATCH,
        REPORT
    } stateT;

    // Terminal counts: the run counter and the gate counter both count from 0.
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);

    stateT           state;
    logic            syncA;
    logic            syncB;
    logic            filt;
    logic [CW-1:0]   runCnt;
    logic [CW-1:0]   gateCnt;
    logic            riseNext;

    // Two-flop synchronizer followed by a run-length debounce on the synchronized sample.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            syncA  <= 1'b0;
            syncB  <= 1'b0;
            filt   <= 1'b0;
            runCnt <= '0;
        end else begin
            syncA <= iSenal;
            syncB <= syncA;
            if (syncB != filt) begin
                if (runCnt == DEB_LAST) begin
                    filt   <= syncB;
                    runCnt <= '0;
                end else begin
                    runCnt <= runCnt + 1'b1;
                end
            end else begin
                runCnt <= '0;
            end
        end
    end

    // High in the cycle whose clock edge will raise the filtered level. Registering this
    // into oCntInc makes the increment strobe coincide with the cycle the edge is seen,
    // so the strobe stays inside the gate window even for an edge in the last gate cycle.
    assign riseNext = syncB & ~filt & (runCnt == DEB_LAST);

    // Measurement sequencer; every output is a flop set on the transition into its state.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state      <= IDLE;
            gateCnt    <= '0;
            oCntClr    <= 1'b0;
            oCntInc    <= 1'b0;
            oLatch     <= 1'b0;
            oGate      <= 1'b0;
            oBusy      <= 1'b0;
            oValid     <= 1'b0;
            oOverrange <= 1'b0;
        end else begin
            oCntClr <= 1'b0;
            oCntInc <= 1'b0;
            oLatch  <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        state      <= CLEAR;
                        oCntClr    <= 1'b1;
                        oBusy      <= 1'b1;
                        oOverrange <= 1'b0;
                        gateCnt    <= '0;
                    end
                end
                CLEAR: begin
                    state   <= GATE;
                    oGate   <= 1'b1;
                    gateCnt <= '0;
                    oCntInc <= riseNext;
                end
                GATE: begin
                    if (iOvf) begin
                        oOverrange <= 1'b1;
                    end
                    if (gateCnt == GATE_LAST) begin
                        state  <= LATCH;
                        oGate  <= 1'b0;
                        oLatch <= 1'b1;
                    end else begin
                        gateCnt <= gateCnt + 1'b1;
                        oCntInc <= riseNext;
                    end
                end
                LATCH: begin
                    state  <= REPORT;
                    oValid <= 1'b1;
                end
                REPORT: begin
                    if (oValid && iReady) begin
                        oValid <= 1'b0;
                        if (iContinuous) begin
                            state      <= CLEAR;
                            oCntClr    <= 1'b1;
                            oOverrange <= 1'b0;
                            gateCnt    <= '0;
                        end else begin
                            state <= IDLE;
                            oBusy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    oGate  <= 1'b0;
                    oBusy  <= 1'b0;
                    oValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_controller.sv
// tb/tb_freq_gate_controller.sv - directed self-checking bench for freq_gate_controller
module tb_freq_gate_controller;

    logic iClk = 1'b0;
    logic iReset = 1'b1;
    logic iSenal = 1'b0;
    logic iStart = 1'b0;
    logic iContinuous = 1'b0;
    logic iOvf = 1'b0;
    logic iReady = 1'b0;
    logic oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange;

    int checks = 0;
    int errors = 0;
    int incCount, gateCount, latchCount, clrCount, badCount;
    int mode = 0;
    int level = 0;
    int phase = 0;
    bit ok;

    freq_gate_controller dut (
        .iClk(iClk), .iReset(iReset), .iSenal(iSenal), .iStart(iStart),
        .iContinuous(iContinuous), .iOvf(iOvf), .iReady(iReady),
        .oCntClr(oCntClr), .oCntInc(oCntInc), .oLatch(oLatch), .oGate(oGate),
        .oBusy(oBusy), .oValid(oValid), .oOverrange(oOverrange)
    );

    always #20 iClk = ~iClk;

    task automatic clearMon();
        incCount = 0; gateCount = 0; latchCount = 0; clrCount = 0; badCount = 0;
    endtask

    // one clock: sample outputs 5 ns after the edge, then drive the next iSenal value
    task automatic tick();
        @(posedge iClk);
        #5;
        if (oCntInc) incCount++;
        if (oGate) gateCount++;
        if (oLatch) latchCount++;
        if (oCntClr) clrCount++;
        if ((oCntInc && !oGate) || (int'(oCntClr) + int'(oCntInc) + int'(oLatch) > 1)) badCount++;
        phase = (phase + 1) % 10;
        case (mode)
            1: iSenal = (phase < 5);
            2: iSenal = (iSenal == 1'b0) && ($urandom_range(0, 3) == 0);
            default: iSenal = level[0];
        endcase
    endtask

    task automatic waitLatch(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (oLatch) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitGate(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (oGate) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange});
        end
        iReset = 1'b0;
        tick(); tick();
        checks++;
        if ({oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange} !== 7'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b want 0000000",
                     {oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange});
        end
    endtask

    task automatic test_square();
        mode = 1;
        for (int i = 0; i < 20; i++) tick();
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        checks++;
        if (oCntClr !== 1'b1 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL sq_clear: clr=%b busy=%b want 1 1", oCntClr, oBusy);
        end
        waitLatch(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL sq_latch_timeout: latch=0 want 1"); end
        checks++;
        if (gateCount != 50) begin errors++; $display("FAIL sq_gate_len: got %0d want 50", gateCount); end
        checks++;
        if (incCount != 5) begin errors++; $display("FAIL sq_inc_count: got %0d want 5", incCount); end
        checks++;
        if (clrCount != 1 || badCount != 0) begin
            errors++;
            $display("FAIL sq_strobes: clr=%0d bad=%0d want 1 0", clrCount, badCount);
        end
        tick();
        checks++;
        if (oValid !== 1'b1 || oGate !== 1'b0) begin
            errors++;
            $display("FAIL sq_valid: valid=%b gate=%b want 1 0", oValid, oGate);
        end
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checks++;
        if (oValid !== 1'b0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL sq_handoff: valid=%b busy=%b want 0 0", oValid, oBusy);
        end
    endtask

    task automatic test_glitch();
        mode = 2;
        for (int i = 0; i < 10; i++) tick();
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitLatch(ok);
        checks++;
        if (!ok || gateCount != 50 || incCount != 0) begin
            errors++;
            $display("FAIL glitch_inc: latched=%0d gate=%0d inc=%0d want 1 50 0", ok, gateCount, incCount);
        end
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        mode = 0;
        level = 1;
        for (int i = 0; i < 12; i++) tick();
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitLatch(ok);
        checks++;
        if (!ok || incCount != 0) begin
            errors++;
            $display("FAIL stable_high_inc: latched=%0d inc=%0d want 1 0", ok, incCount);
        end
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        level = 0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_back_pressure();
        int gap;
        mode = 0;
        level = 0;
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitLatch(ok);
        tick();
        iContinuous = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (oValid !== 1'b1 || oCntClr !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b clr=%b want 1 0", i, oValid, oCntClr);
            end
        end
        iReady = 1'b1;
        tick();
        checks++;
        if (oValid !== 1'b0 || oCntClr !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b clr=%b want 0 1", oValid, oCntClr);
        end
        waitLatch(ok);
        gap = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            gap++;
            if (oLatch) break;
        end
        iContinuous = 1'b0;
        checks++;
        if (gap != 53) begin errors++; $display("FAIL latch_period: got %0d want 53", gap); end
        tick(); tick(); tick();
        iReady = 1'b0;
        checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0 || badCount != 0) begin
            errors++;
            $display("FAIL bp_stop: busy=%b valid=%b bad=%0d want 0 0 0", oBusy, oValid, badCount);
        end
    endtask

    task automatic test_overrange();
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitGate(ok);
        for (int i = 0; i < 10; i++) tick();
        iOvf = 1'b1;
        tick();
        iOvf = 1'b0;
        waitLatch(ok);
        tick();
        checks++;
        if (oValid !== 1'b1 || oOverrange !== 1'b1) begin
            errors++;
            $display("FAIL ovf_at_valid: valid=%b ovr=%b want 1 1", oValid, oOverrange);
        end
        tick(); tick(); tick();
        checks++;
        if (oOverrange !== 1'b1) begin errors++; $display("FAIL ovf_held: got %b want 1", oOverrange); end
        iContinuous = 1'b1;
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        iContinuous = 1'b0;
        checks++;
        if (oCntClr !== 1'b1 || oOverrange !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: clr=%b ovr=%b want 1 0", oCntClr, oOverrange);
        end
        waitLatch(ok);
        tick();
        checks++;
        if (oValid !== 1'b1 || oOverrange !== 1'b0) begin
            errors++;
            $display("FAIL ovf_next_meas: valid=%b ovr=%b want 1 0", oValid, oOverrange);
        end
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
    endtask

    task automatic test_reset_mid_gate();
        mode = 1;
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitGate(ok);
        while (gateCount < 20) tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        checks++;
        if ({oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange} !== 7'b0) begin
            errors++;
            $display("FAIL midgate_reset: got %b want 0000000",
                     {oCntClr, oCntInc, oLatch, oGate, oBusy, oValid, oOverrange});
        end
        for (int i = 0; i < 60; i++) tick();
        checks++;
        if (latchCount != 0 || oBusy !== 1'b0) begin
            errors++;
            $display("FAIL midgate_no_latch: latches=%0d busy=%b want 0 0", latchCount, oBusy);
        end
        clearMon();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitLatch(ok);
        checks++;
        if (!ok || gateCount != 50 || incCount != 5 || badCount != 0) begin
            errors++;
            $display("FAIL fresh_gate: latched=%0d gate=%0d inc=%0d bad=%0d want 1 50 5 0",
                     ok, gateCount, incCount, badCount);
        end
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        mode = 0;
        level = 0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_start_held();
        clearMon();
        iContinuous = 1'b0;
        iStart = 1'b1;
        tick();
        waitLatch(ok);
        checks++;
        if (!ok || clrCount != 1) begin
            errors++;
            $display("FAIL held_single: latched=%0d clr=%0d want 1 1", ok, clrCount);
        end
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checks++;
        if (oBusy !== 1'b0 || oValid !== 1'b0 || oCntClr !== 1'b0) begin
            errors++;
            $display("FAIL held_idle: busy=%b valid=%b clr=%b want 0 0 0", oBusy, oValid, oCntClr);
        end
        tick();
        iStart = 1'b0;
        checks++;
        if (oCntClr !== 1'b1 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL held_restart: clr=%b busy=%b want 1 1", oCntClr, oBusy);
        end
        waitLatch(ok);
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        checks++;
        if (oBusy !== 1'b0 || badCount != 0) begin
            errors++;
            $display("FAIL held_end: busy=%b bad=%0d want 0 0", oBusy, badCount);
        end
    endtask

    initial begin
        clearMon();
        test_reset();
        test_square();
        test_glitch();
        test_back_pressure();
        test_overrange();
        test_reset_mid_gate();
        test_start_held();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
